// File: rtl/fifo_ram_ctrl.sv
// Circular-buffer controller for a DEPTH x WIDTH dual-port RAM with a 1-cycle registered read.
// Latency: RAM enables are combinational from push/pop. Flags follow one cycle after the accepting edge. rd_valid trails an accepted pop by 1 cycle.
// Backpressure: a push while full or a pop while empty is dropped, and the matching sticky error flag is set.
module fifo_ram_ctrl #(
  parameter int DEPTH    = 64,
  parameter int AW       = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clr_err,
  output logic          ram_w_en,
  output logic [AW-1:0] ram_w_addr,
  output logic          ram_r_en,
  output logic [AW-1:0] ram_r_addr,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_C     = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_C     = (AW+1)'(AE_LEVEL);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Status flags are decoded from the registered count only.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // At full, a simultaneous pop still drains one entry while the push is refused.
  // At empty, a simultaneous push fills one entry while the pop is refused. There is no fall-through.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign ram_w_en   = push_ok;
  assign ram_r_en   = pop_ok;
  assign ram_w_addr = wr_ptr;
  assign ram_r_addr = rd_ptr;

  // Advance each pointer on an accepted request.
  // The wrap uses an explicit compare so that DEPTH does not need to be a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Track occupancy.
  // When a push and a pop are both accepted, the count is left unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Mirror the RAM's single-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= pop_ok;
  end

  // Sticky error flags.
  // A new error in the same cycle as clr_err takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full)  overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (pop & empty)  underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench for fifo_ram_ctrl with a behavioural RAM and a queue-based reference model.
// Latency: inputs are driven on the falling edge, and outputs are sampled 1 time unit later.
// Backpressure: the push/pop mix covers the full, empty and wrap conditions.
module tb_fifo_ram_ctrl;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int AFL   = DEPTH - 4;
  localparam int AEL   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic          ram_w_en, ram_r_en, rd_valid;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  logic [15:0]   wdata = '0;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state: stored data as a queue, plus pointers derived from simple modulo arithmetic.
  int mq[$];
  int m_wp, m_rp, m_rdat, wval;
  bit m_ovf, m_uf, m_rdv;

  fifo_ram_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr_err(clr_err),
    .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_r_en(ram_r_en),
    .ram_r_addr(ram_r_addr), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM with a registered read port.
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_w_addr] <= wdata;
    if (ram_r_en) rdata <= mem[ram_r_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wp = 0; m_rp = 0; m_ovf = 0; m_uf = 0; m_rdv = 0; m_rdat = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = 0; pop = 0; clr_err = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  // Run one cycle: check every output against the model, then advance the model.
  task automatic step(input bit p, input bit q, input bit c);
    int cnt;
    bit ap, aq;
    @(negedge clk);
    push = p; pop = q; clr_err = c; wdata = wval[15:0];
    #1;
    cnt = mq.size();
    ap = p && (cnt < DEPTH);
    aq = q && (cnt > 0);
    chk("count", count, cnt);
    chk("full", full, cnt == DEPTH);
    chk("empty", empty, cnt == 0);
    chk("almost_full", almost_full, cnt >= AFL);
    chk("almost_empty", almost_empty, cnt <= AEL);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_uf);
    chk("rd_valid", rd_valid, m_rdv);
    if (m_rdv) chk("rd_data", rdata, m_rdat);
    chk("ram_w_en", ram_w_en, ap);
    chk("ram_r_en", ram_r_en, aq);
    if (ap) chk("ram_w_addr", ram_w_addr, m_wp);
    if (aq) chk("ram_r_addr", ram_r_addr, m_rp);
    if (p && cnt == DEPTH) m_ovf = 1; else if (c) m_ovf = 0;
    if (q && cnt == 0)     m_uf = 1;  else if (c) m_uf = 0;
    m_rdv = aq;
    if (aq) begin
      m_rdat = mq.pop_front();
      m_rp = (m_rp + 1) % DEPTH;
    end
    if (ap) begin
      mq.push_back(wval & 16'hFFFF);
      m_wp = (m_wp + 1) % DEPTH;
      wval++;
    end
  endtask

  typedef struct {
    bit p, q, c;
    bit ew, er;
    int ecnt;
    bit euf;
  } vec_t;
  vec_t vt[11];

  initial begin
    vt[0]  = '{0, 1, 0, 0, 0, 0, 1};
    vt[1]  = '{0, 0, 1, 0, 0, 0, 0};
    vt[2]  = '{1, 0, 0, 1, 0, 1, 0};
    vt[3]  = '{1, 1, 0, 1, 1, 1, 0};
    vt[4]  = '{1, 0, 0, 1, 0, 2, 0};
    vt[5]  = '{1, 1, 0, 1, 1, 2, 0};
    vt[6]  = '{0, 1, 0, 0, 1, 1, 0};
    vt[7]  = '{0, 1, 0, 0, 1, 0, 0};
    vt[8]  = '{1, 1, 1, 1, 0, 1, 1};
    vt[9]  = '{0, 0, 1, 0, 0, 1, 0};
    vt[10] = '{0, 1, 0, 0, 1, 0, 0};
    wval = 0;

    do_reset();

    // Apply the table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      push = vt[i].p; pop = vt[i].q; clr_err = vt[i].c;
      #1;
      chk($sformatf("vec%0d_w_en", i), ram_w_en, vt[i].ew);
      chk($sformatf("vec%0d_r_en", i), ram_r_en, vt[i].er);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", i), count, vt[i].ecnt);
      chk($sformatf("vec%0d_uf", i), underflow, vt[i].euf);
    end

    // Reset, then stay idle.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // Fill with 0..63, then check that overflow is refused while a simultaneous pop is accepted.
    wval = 0;
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    step(0, 0, 0);
    chk("fill_full", full, 1);
    step(1, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("after_clr_ovf", overflow, 0);

    // Drain, then push and pop together while empty.
    for (int i = 0; i < DEPTH - 1; i++) step(0, 1, 0);
    step(0, 0, 0);
    chk("drain_empty", empty, 1);
    step(1, 1, 0);
    step(0, 0, 0);
    chk("empty_pp_count", count, 1);
    chk("empty_pp_uf", underflow, 1);

    // Stream push and pop together across the pointer wrap.
    do_reset();
    for (int i = 0; i < 60; i++) step(1, 0, 0);
    for (int i = 0; i < 50; i++) step(0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 1, 0);
    step(0, 0, 0);
    chk("wrap_count", count, 10);

    // Randomised phases that alternate between push-heavy and pop-heavy traffic.
    for (int i = 0; i < 800; i++) begin
      bit ph;
      ph = ((i / 100) % 2) == 0;
      step(($urandom_range(99) < (ph ? 85 : 30)),
           ($urandom_range(99) < (ph ? 30 : 85)),
           ($urandom_range(99) < 5));
    end

    // Assert reset asynchronously mid-stream with pop active.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    @(negedge clk);
    push = 0; pop = 1; clr_err = 0;
    #2;
    rst_n = 0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    @(posedge clk);
    #1;
    chk("arst_rd_valid", rd_valid, 0);
    @(negedge clk);
    pop = 0;
    rst_n = 1;
    model_reset();
    step(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
